// File: rtl/phase_accum_if.sv
// Control/status bundle for the phase accumulator.
// The master drives control; the slave (accumulator) returns addresses and status.
interface phase_accum_if #(
  parameter int A_WIDTH = 8
) ();
  logic               en;
  logic [1:0]         mode;
  logic [A_WIDTH-1:0] incr;
  logic               load;
  logic [A_WIDTH-1:0] load_val;
  logic [A_WIDTH-1:0] offset;
  logic [A_WIDTH-1:0] count;
  logic [A_WIDTH-1:0] count_off;
  logic               dir;
  logic               evt;

  modport master (
    output en, mode, incr, load, load_val, offset,
    input  count, count_off, dir, evt
  );

  modport slave (
    input  en, mode, incr, load, load_val, offset,
    output count, count_off, dir, evt
  );
endinterface

// File: rtl/phase_accum.sv
// Phase accumulator / ROM address generator with wrap, saturate,
// triangle and down-wrap stepping plus an offset second channel.
module phase_accum #(
  parameter int A_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  phase_accum_if.slave  bus
);
  typedef enum logic [1:0] {
    M_WRAP = 2'b00,
    M_SAT  = 2'b01,
    M_TRI  = 2'b10,
    M_DOWN = 2'b11
  } mode_e;

  localparam logic [A_WIDTH-1:0] MAX = '1;

  logic [A_WIDTH-1:0] r_count;
  logic [A_WIDTH-1:0] r_count_off;
  logic               r_dir;
  logic               r_evt;

  logic [A_WIDTH:0]   w_sum;
  logic [A_WIDTH:0]   w_refl;
  logic               w_over;
  logic               w_borrow;
  logic [A_WIDTH-1:0] w_diff;
  logic [A_WIDTH-1:0] w_rdiff;
  logic [A_WIDTH-1:0] w_nxt;
  logic               w_nxt_dir;
  logic               w_nxt_evt;

  // MAX is all ones, so the carry bit alone means s > MAX
  assign w_sum    = {1'b0, r_count} + {1'b0, bus.incr};
  assign w_over   = w_sum[A_WIDTH];
  assign w_refl   = {MAX, 1'b0} - w_sum;
  assign w_borrow = r_count < bus.incr;
  assign w_diff   = r_count - bus.incr;
  assign w_rdiff  = bus.incr - r_count;

  always_comb begin
    w_nxt     = r_count;
    w_nxt_dir = r_dir;
    w_nxt_evt = 1'b0;
    if (bus.load) begin
      w_nxt     = bus.load_val;
      w_nxt_dir = 1'b1;
    end else if (bus.en) begin
      unique case (mode_e'(bus.mode))
        M_WRAP: begin
          w_nxt     = w_sum[A_WIDTH-1:0];
          w_nxt_evt = w_over;
        end
        M_SAT: begin
          w_nxt     = w_over ? MAX : w_sum[A_WIDTH-1:0];
          w_nxt_evt = (r_count != MAX) && (w_nxt == MAX);
        end
        M_TRI: begin
          if (r_dir) begin
            if (w_over) begin
              w_nxt     = w_refl[A_WIDTH-1:0];
              w_nxt_dir = 1'b0;
              w_nxt_evt = 1'b1;
            end else begin
              w_nxt = w_sum[A_WIDTH-1:0];
            end
          end else if (w_borrow) begin
            w_nxt     = w_rdiff;
            w_nxt_dir = 1'b1;
            w_nxt_evt = 1'b1;
          end else begin
            w_nxt = w_diff;
          end
        end
        M_DOWN: begin
          w_nxt     = w_diff;
          w_nxt_evt = w_borrow;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count     <= '0;
      r_count_off <= '0;
      r_dir       <= 1'b1;
      r_evt       <= 1'b0;
    end else begin
      r_count     <= w_nxt;
      r_count_off <= w_nxt + bus.offset;
      r_dir       <= w_nxt_dir;
      r_evt       <= w_nxt_evt;
    end
  end

  assign bus.count     = r_count;
  assign bus.count_off = r_count_off;
  assign bus.dir       = r_dir;
  assign bus.evt       = r_evt;
endmodule

// File: tb/tb_phase_accum.sv
// Directed bench for phase_accum (A_WIDTH=8) with
// hand-computed expectations checked by immediate assertions.
module tb_phase_accum;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  phase_accum_if #(.A_WIDTH(8)) bus ();

  phase_accum #(.A_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int co,
                         input int d, input int e);
    chk({tag, ".count"}, int'(bus.count), c);
    chk({tag, ".count_off"}, int'(bus.count_off), co);
    chk({tag, ".dir"}, int'(bus.dir), d);
    chk({tag, ".evt"}, int'(bus.evt), e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.mode = 2'b00;
    bus.incr = 8'd5;
    bus.load = 1'b0;
    bus.load_val = 8'd0;
    bus.offset = 8'd0;

    // reset held two edges with en active
    step();
    step();
    chk_all("rst", 0, 0, 1, 0);
    rst = 1'b1;
    step(); chk("run1", int'(bus.count), 5);
    step(); chk("run2", int'(bus.count), 10);
    step(); chk("run3", int'(bus.count), 15);

    // WRAP
    bus.load = 1'b1; bus.load_val = 8'd250; bus.incr = 8'd10;
    step(); chk("wrap.ld", int'(bus.count), 250);
    bus.load = 1'b0;
    step(); chk_all("wrap.1", 4, 4, 1, 1);
    step(); chk_all("wrap.2", 14, 14, 1, 0);

    // SAT
    bus.mode = 2'b01; bus.load = 1'b1; bus.load_val = 8'd250; bus.incr = 8'd3;
    step();
    bus.load = 1'b0;
    step(); chk_all("sat.1", 253, 253, 1, 0);
    step(); chk_all("sat.2", 255, 255, 1, 1);
    step(); chk_all("sat.3", 255, 255, 1, 0);
    bus.mode = 2'b00;
    step(); chk_all("sat.wrap", 2, 2, 1, 1);

    // TRI reflect at top
    bus.mode = 2'b10; bus.load = 1'b1; bus.load_val = 8'd250; bus.incr = 8'd10;
    step(); chk("tri.ld", int'(bus.count), 250);
    bus.load = 1'b0;
    step(); chk_all("tri.top", 250, 250, 0, 1);
    step(); chk_all("tri.dn", 240, 240, 0, 0);
    // WRAP keeps dir=0 while moving count to 3
    bus.mode = 2'b00; bus.incr = 8'd19;
    step(); chk_all("tri.wrap", 3, 3, 0, 1);
    bus.mode = 2'b10; bus.incr = 8'd10;
    step(); chk_all("tri.bot", 7, 7, 1, 1);
    // landing exactly on MAX is not a reflect
    bus.load = 1'b1; bus.load_val = 8'd245;
    step();
    bus.load = 1'b0;
    step(); chk_all("tri.max", 255, 255, 1, 0);
    step(); chk_all("tri.max2", 245, 245, 0, 1);

    // DOWN with offset channel
    bus.mode = 2'b11; bus.load = 1'b1; bus.load_val = 8'd4;
    bus.incr = 8'd10; bus.offset = 8'd128;
    step(); chk_all("down.ld", 4, 132, 1, 0);
    bus.load = 1'b0;
    step(); chk_all("down.1", 250, 122, 1, 1);
    bus.offset = 8'd0; bus.en = 1'b0;
    step(); chk_all("down.hold", 250, 250, 1, 0);

    // priority
    bus.en = 1'b1; bus.load = 1'b1; bus.load_val = 8'd77;
    step(); chk_all("pri.ld", 77, 77, 1, 0);
    rst = 1'b0;
    step(); chk_all("pri.rst", 0, 0, 1, 0);
    rst = 1'b1; bus.load_val = 8'd100;
    step(); chk("pri.ld2", int'(bus.count), 100);
    bus.load = 1'b0; bus.incr = 8'd0;
    for (int m = 0; m < 4; m++) begin
      bus.mode = 2'(m);
      step();
      chk_all($sformatf("zero.m%0d", m), 100, 100, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
